// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and integer register file.
// Formats load data, picks the write-back value, commits it to a
// NUM_REGS x XLEN register file (x0 hardwired to zero) and serves two
// combinational read ports with write-through bypass. Counts retired writes.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   LoadMux[1:0]         load format (word / half signed / byte signed / byte unsigned)
//   MemToReg[1:0]        write-back source (ALU / load / PC+4 / ALU)
//   RegWrite             write enable
//   ALUResult            ALU result, [1:0] is the load byte offset
//   MemContent           raw aligned memory word
//   PCplus4              link value
//   RdAddress            destination register
//   Rs1Address/Rs2Address decode read addresses
//   Rs1Data/Rs2Data      combinational read data
//   WBData               selected write-back value (combinational)
//   WBValid              RegWrite && RdAddress != 0 (combinational)
//   WBCount              committed register writes since reset (registered)
module wb_regfile #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  LoadMux,
    input  logic [1:0]                  MemToReg,
    input  logic                        RegWrite,
    input  logic [XLEN-1:0]             ALUResult,
    input  logic [XLEN-1:0]             MemContent,
    input  logic [XLEN-1:0]             PCplus4,
    input  logic [$clog2(NUM_REGS)-1:0] RdAddress,
    input  logic [$clog2(NUM_REGS)-1:0] Rs1Address,
    input  logic [$clog2(NUM_REGS)-1:0] Rs2Address,
    output logic [XLEN-1:0]             Rs1Data,
    output logic [XLEN-1:0]             Rs2Data,
    output logic [XLEN-1:0]             WBData,
    output logic                        WBValid,
    output logic [XLEN-1:0]             WBCount
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] wb_count_q, wb_count_d;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    // Load byte/halfword extraction and extension
    always_comb begin
        load_byte = '0;
        load_half = '0;
        load_data = '0;
        case (ALUResult[1:0])
            2'd0:    load_byte = MemContent[7:0];
            2'd1:    load_byte = MemContent[15:8];
            2'd2:    load_byte = MemContent[23:16];
            default: load_byte = MemContent[31:24];
        endcase
        load_half = ALUResult[1] ? MemContent[31:16] : MemContent[15:0];
        case (LoadMux)
            2'd0:    load_data = MemContent;
            2'd1:    load_data = {{(XLEN-16){load_half[15]}}, load_half};
            2'd2:    load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            default: load_data = {{(XLEN-8){1'b0}}, load_byte};
        endcase
    end

    // Write-back source select and commit qualifier
    always_comb begin
        WBData = ALUResult;
        case (MemToReg)
            2'd1:    WBData = load_data;
            2'd2:    WBData = PCplus4;
            default: WBData = ALUResult;
        endcase
        WBValid = RegWrite && (RdAddress != AW'(0));
    end

    // Read ports: x0 forced to zero, current write-back bypassed over storage
    always_comb begin
        Rs1Data = regs_q[Rs1Address];
        Rs2Data = regs_q[Rs2Address];
        if (WBValid && (Rs1Address == RdAddress)) Rs1Data = WBData;
        if (WBValid && (Rs2Address == RdAddress)) Rs2Data = WBData;
        if (Rs1Address == AW'(0)) Rs1Data = '0;
        if (Rs2Address == AW'(0)) Rs2Data = '0;
    end

    always_comb begin
        wb_count_d = wb_count_q;
        if (WBValid) wb_count_d = wb_count_q + XLEN'(1);
    end

    // Storage and counter; reset wins over a coincident commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            wb_count_q <= '0;
        end else begin
            if (WBValid) regs_q[RdAddress] <= WBData;
            wb_count_q <= wb_count_d;
        end
    end

    assign WBCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  LoadMux, MemToReg;
    logic        RegWrite;
    logic [31:0] ALUResult, MemContent, PCplus4;
    logic [4:0]  RdAddress, Rs1Address, Rs2Address;
    logic [31:0] Rs1Data, Rs2Data, WBData, WBCount;
    logic        WBValid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .LoadMux(LoadMux), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUResult(ALUResult), .MemContent(MemContent),
        .PCplus4(PCplus4), .RdAddress(RdAddress), .Rs1Address(Rs1Address),
        .Rs2Address(Rs2Address), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
        .WBData(WBData), .WBValid(WBValid), .WBCount(WBCount)
    );

    typedef struct {
        string       name;
        logic [1:0]  lm, m2r;
        logic        we;
        logic [31:0] alu, mem, pc4;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] e_wb;
        logic        e_valid;
        logic [31:0] e_rs1, e_rs2, e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] lm, input logic [1:0] m2r,
                         input logic we, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst = r; LoadMux = lm; MemToReg = m2r; RegWrite = we; ALUResult = alu;
        MemContent = mem; PCplus4 = pc4; RdAddress = rd; Rs1Address = a1; Rs2Address = a2;
    endtask

    function automatic vec_t mk(string n, logic [1:0] lm, logic [1:0] m2r, logic we,
                                logic [31:0] alu, logic [31:0] mem, logic [31:0] pc4,
                                logic [4:0] rd, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] ewb, logic ev, logic [31:0] e1,
                                logic [31:0] e2, logic [31:0] ec);
        vec_t v;
        v.name = n; v.lm = lm; v.m2r = m2r; v.we = we; v.alu = alu; v.mem = mem;
        v.pc4 = pc4; v.rd = rd; v.rs1 = a1; v.rs2 = a2; v.e_wb = ewb; v.e_valid = ev;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_cnt = ec;
        return v;
    endfunction

    localparam logic [31:0] MC = 32'h80F1_7F85;

    initial begin
        //              name       lm m2r we alu           mem pc4      rd  rs1 rs2 wb            v  rs1           rs2           cnt
        vecs.push_back(mk("wr_x5",   0, 0, 1, 32'h12345678, 0,  0,       5,  5,  0, 32'h12345678, 1, 32'h12345678, 0,            1));
        vecs.push_back(mk("rd_x5",   0, 0, 0, 0,            0,  0,       5,  5,  5, 0,            0, 32'h12345678, 32'h12345678, 1));
        vecs.push_back(mk("lb_o0",   2, 1, 1, 32'h100,      MC, 0,       10, 10, 5, 32'hFFFFFF85, 1, 32'hFFFFFF85, 32'h12345678, 2));
        vecs.push_back(mk("lbu_o0",  3, 1, 1, 32'h100,      MC, 0,       11, 11, 10,32'h00000085, 1, 32'h00000085, 32'hFFFFFF85, 3));
        vecs.push_back(mk("lb_o1",   2, 1, 1, 32'h101,      MC, 0,       12, 12, 11,32'h0000007F, 1, 32'h0000007F, 32'h00000085, 4));
        vecs.push_back(mk("lh_o2",   1, 1, 1, 32'h102,      MC, 0,       13, 13, 12,32'hFFFF80F1, 1, 32'hFFFF80F1, 32'h0000007F, 5));
        vecs.push_back(mk("lw",      0, 1, 1, 32'h103,      MC, 0,       14, 14, 13,32'h80F17F85, 1, 32'h80F17F85, 32'hFFFF80F1, 6));
        vecs.push_back(mk("lbu_o3",  3, 1, 1, 32'h003,      MC, 0,       15, 15, 14,32'h00000080, 1, 32'h00000080, 32'h80F17F85, 7));
        vecs.push_back(mk("lh_o1",   1, 1, 1, 32'h001,      MC, 0,       16, 16, 15,32'h00007F85, 1, 32'h00007F85, 32'h00000080, 8));
        vecs.push_back(mk("lh_o3",   1, 1, 1, 32'h003,      MC, 0,       17, 0,  16,32'hFFFF80F1, 1, 0,            32'h00007F85, 9));
        vecs.push_back(mk("link_x1", 0, 2, 1, 32'hDEAD,     MC, 32'h1004,1,  1,  17,32'h00001004, 1, 32'h00001004, 32'hFFFF80F1, 10));
        vecs.push_back(mk("link_x0", 0, 2, 1, 32'hDEAD,     MC, 32'h1004,0,  0,  1, 32'h00001004, 0, 0,            32'h00001004, 10));
        vecs.push_back(mk("m2r3",    0, 3, 1, 32'hCAFE,     MC, 32'h1004,2,  2,  0, 32'h0000CAFE, 1, 32'h0000CAFE, 0,            11));
        vecs.push_back(mk("dual_byp",0, 0, 1, 32'd1000,     0,  0,       7,  7,  7, 32'd1000,     1, 32'd1000,     32'd1000,     12));
        vecs.push_back(mk("dual_old",0, 0, 0, 32'd3000,     0,  0,       7,  7,  7, 32'd3000,     0, 32'd1000,     32'd1000,     12));
        vecs.push_back(mk("b2b_1",   0, 0, 1, 32'd4000,     0,  0,       7,  7,  2, 32'd4000,     1, 32'd4000,     32'h0000CAFE, 13));
        vecs.push_back(mk("b2b_2",   0, 0, 1, 32'd5000,     0,  0,       7,  7,  7, 32'd5000,     1, 32'd5000,     32'd5000,     14));
        vecs.push_back(mk("b2b_rd",  0, 2, 0, 32'd6000,     0,  32'h20,  7,  7,  1, 32'h00000020, 0, 32'd5000,     32'h00001004, 14));

        // Reset for two edges
        drive(1, 0, 0, 0, 0, 0, 0, 0, 5, 9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", WBCount, 0);
        chk("rst_rs1", Rs1Data, 0);
        chk("rst_rs2", Rs2Data, 0);

        foreach (vecs[i]) begin
            drive(0, vecs[i].lm, vecs[i].m2r, vecs[i].we, vecs[i].alu, vecs[i].mem,
                  vecs[i].pc4, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk({vecs[i].name, ".wb"},    WBData,  vecs[i].e_wb);
            chk({vecs[i].name, ".valid"}, 32'(WBValid), 32'(vecs[i].e_valid));
            chk({vecs[i].name, ".rs1"},   Rs1Data, vecs[i].e_rs1);
            chk({vecs[i].name, ".rs2"},   Rs2Data, vecs[i].e_rs2);
            @(posedge clk); #1;
            chk({vecs[i].name, ".cnt"},   WBCount, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Storage holds after MEM/WB moves on
        drive(0, 0, 0, 0, 32'h0, 0, 0, 9, 5, 13);
        #1;
        chk("hold_x5",  Rs1Data, 32'h12345678);
        chk("hold_x13", Rs2Data, 32'hFFFF80F1);

        // Reset collision: x3=0xAA, then reset with a write of 0x55 to x3
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hAA, 0, 0, 3, 3, 0);
        @(posedge clk); #1;
        chk("x3_aa_cnt", WBCount, 15);
        @(negedge clk);
        drive(1, 0, 0, 1, 32'h55, 0, 0, 3, 3, 0);
        #1;
        chk("rstcol_wb",  WBData, 32'h55);
        chk("rstcol_val", 32'(WBValid), 1);
        chk("rstcol_byp", Rs1Data, 32'h55);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h0, 0, 0, 3, 3, 5);
        #1;
        chk("rstcol_x3",  Rs1Data, 0);
        chk("rstcol_x5",  Rs2Data, 0);
        chk("rstcol_cnt", WBCount, 0);

        // Reset release mid-stream: first commit is on the first rst=0 edge
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h44, 0, 0, 4, 4, 3);
        @(posedge clk); #1;
        chk("post_rst_cnt", WBCount, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 0, 4, 3);
        #1;
        chk("post_rst_x4", Rs1Data, 32'h44);
        chk("post_rst_x3", Rs2Data, 0);

        // Counter wrap
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        chk("wrap_pre", WBCount, 32'hFFFF_FFFF);
        drive(0, 0, 0, 1, 32'h77, 0, 0, 6, 6, 0);
        @(posedge clk); #1;
        chk("wrap_cnt", WBCount, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 0, 6, 0);
        #1;
        chk("wrap_x6", Rs1Data, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
